dmem_addr_router: RTL and testbench
===================================

# dmem_addr_router

Parametrised data-bus address router between the core's data-memory port and `NUM_SLAVES` target ports (data RAM, CLIC, future peripherals). Decodes each read/write request against per-slave base/mask windows and gates the request handshake to the selected slave. Routes read data back through a `RD_LAT`-deep select pipeline. Flags unmapped accesses with a sticky error record.

## Interface
- `NUM_SLAVES`, 2: number of target ports, 1..8.
- `SLV_BASE`, {32'h8000_0000, 32'h0000_0000}: packed `NUM_SLAVES*32`; slave i base in bits [32i+31:32i].
- `SLV_MASK`, {32'hF000_0000, 32'hF000_0000}: packed `NUM_SLAVES*32`; address bits compared for slave i.
- `RD_LAT`, 1: read-data latency in cycles after request acceptance, 1..4.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `resetb` in 1: **synchronous, active-high** reset.
- `m_wready` in 1: core write request.
- `m_wvalid` out 1: write accepted.
- `m_waddr` in 32, `m_wdata` in 32, `m_wstrb` in 4: write request fields.
- `m_rready` in 1: core read request.
- `m_rvalid` out 1: read accepted.
- `m_raddr` in 32: read address.
- `m_rresp` out 1: read response OK (1) or error (0).
- `m_rdata` out 32: read data.
- `s_wready` out N: per-slave write request.
- `s_wvalid` in N: per-slave write acceptance.
- `s_waddr` out 32, `s_wdata` out 32, `s_wstrb` out 4: broadcast write fields.
- `s_rready` out N: per-slave read request.
- `s_rvalid` in N: per-slave read acceptance.
- `s_raddr` out 32: broadcast read address.
- `s_rresp` in N: per-slave read response.
- `s_rdata` in N*32: per-slave read data.
- `err_clr` in 1: clears the error record.
- `err` out 1: sticky decode error.
- `err_wr` out 1: captured error was a write.
- `err_addr` out 32: address of the captured error.
- `err_cnt` out 8: saturating decode-error count.

## Operation
- **Decode** (combinational, separately for `m_waddr` and `m_raddr`):
  - Slave i hits when `(addr & MASK[i]) == (BASE[i] & MASK[i])`.
  - On overlapping hits, the lowest index wins.
  - No hit = decode error.
- **Write path:**
  - `s_wready[i] = m_wready && wsel==i`.
  - `m_wvalid = s_wvalid[wsel]`.
  - On decode error: `m_wvalid=1` whenever `m_wready`, the write is dropped, and no `s_wready` bit is set.
- **Read path:**
  - `s_rready[i] = m_rready && rsel==i`.
  - `m_rvalid = s_rvalid[rsel]`, or 1 on decode error.
  - Acceptance is `m_rready && m_rvalid`.
- **Read pipeline:**
  - Each cycle, push entry {acc, idx, derr} into stage 0 and shift all stages by one.
  - The shift is unconditional: latency is fixed, and slaves must present data exactly `RD_LAT` cycles after acceptance.
  - Stage `RD_LAT-1` drives the output:
    - acc && !derr: `m_rdata = s_rdata[idx]`, `m_rresp = s_rresp[idx]`.
    - acc && derr: `m_rdata = 0`, `m_rresp = 0`.
    - !acc: `m_rdata = 0`, `m_rresp = 0`.
- **Error record:**
  - A decode error is a write error (`m_wready` with no hit) or a read error (`m_rready` with no hit).
  - If `err==0`, the next error sets `err=1` and captures `err_addr` and `err_wr`.
  - If `err==1`, later errors only increment `err_cnt`.
  - Write and read errors in the same cycle: the write is captured and `err_cnt` += 2.
  - `err_cnt` saturates at 255.
  - `err_clr` zeroes `err`, `err_wr`, `err_addr` and `err_cnt`.
  - `err_clr` and a new error in the same cycle: the new error is captured and `err_cnt` = 1 (2 for a simultaneous write+read error).
- **Reset:** pipeline stages, `err`, `err_wr`, `err_addr` and `err_cnt` all go to 0.

## Timing
- Request path (`s_wready`, `s_rready`, `m_wvalid`, `m_rvalid`, broadcast fields) is combinational, 0 cycles.
- Read data appears `RD_LAT` cycles after acceptance. Back-to-back reads to different slaves every cycle are legal.
- Error outputs update on the cycle after the error request.
- **Reset values:**
  - Registered outputs (`err`, `err_wr`, `err_addr`, `err_cnt`) are 0 from the first cycle after `resetb` is sampled high.
  - `m_rdata` and `m_rresp` read 0 from the same cycle, because all pipeline stages clear.
  - Combinational outputs follow their inputs throughout.
- **Reset mid-read:** in-flight responses are discarded, with no stale slave data delivered afterwards.
- Inputs are assumed stable in the cycle they are sampled. No request-side buffering: `m_*valid` stays low until the selected slave accepts.

## Test plan
- **Defaults, RD_LAT=1.** Read 0x8000_0010; slave1 `s_rvalid=1`, then `s_rdata[1]`=0x1234_5678 on the next cycle.
  -> `s_rready=2'b10`; `m_rdata`=0x1234_5678, `m_rresp=1` one cycle later; slave0 untouched.
- **RD_LAT=3, alternating reads.** Reads to 0x0000_0000 and 0x8000_0000 on consecutive cycles, slaves returning 0xA0/0xB0.
  -> `m_rdata` shows 0xA0, 0xB0 in order, 3 cycles after each acceptance.
- **Unmapped write.** Write to 0x4000_0004.
  -> `m_wvalid=1`, `s_wready=0`; next cycle `err=1`, `err_wr=1`, `err_addr`=0x4000_0004, `err_cnt`=1.
- **Error accounting.**
  - Same-cycle unmapped write 0x4000_0000 and read 0x5000_0000 -> `err_addr`=0x4000_0000, `err_cnt`=2.
  - 300 further errors -> `err_cnt`=255.
  - `err_clr` with a concurrent read error at 0x6000_0000 -> `err_addr`=0x6000_0000, `err_cnt`=1.
- **Reset mid-read.** Assert `resetb` the cycle after a read is accepted with RD_LAT=2.
  -> `m_rresp=0` and `m_rdata=0` for every cycle after reset is sampled; error outputs 0.
- **Overlap.** `SLV_MASK` all 0 for both slaves (both always hit).
  -> Every access goes to slave0 and no errors are recorded.

Source files
------------

// File: rtl/dmem_addr_router.sv
// Data-bus address router: base/mask decode of core read/write requests onto NUM_SLAVES
// target ports, fixed-latency read-data return and a sticky decode-error record.
module dmem_addr_router #(
    parameter int                       NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {32'hF000_0000, 32'hF000_0000},
    parameter int                       RD_LAT     = 1
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       m_wready,
    output logic                       m_wvalid,
    input  logic [31:0]                m_waddr,
    input  logic [31:0]                m_wdata,
    input  logic [3:0]                 m_wstrb,
    input  logic                       m_rready,
    output logic                       m_rvalid,
    input  logic [31:0]                m_raddr,
    output logic                       m_rresp,
    output logic [31:0]                m_rdata,
    output logic [NUM_SLAVES-1:0]      s_wready,
    input  logic [NUM_SLAVES-1:0]      s_wvalid,
    output logic [31:0]                s_waddr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    output logic [NUM_SLAVES-1:0]      s_rready,
    input  logic [NUM_SLAVES-1:0]      s_rvalid,
    output logic [31:0]                s_raddr,
    input  logic [NUM_SLAVES-1:0]      s_rresp,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    input  logic                       err_clr,
    output logic                       err,
    output logic                       err_wr,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_cnt
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    // Returns {hit, index}; scanning upward and keeping the first match gives lowest-index priority.
    function automatic logic [IDX_W:0] decode(input logic [31:0] addr);
        logic             hit;
        logic             match;
        logic [IDX_W-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match = ((addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]));
            idx   = (match && !hit) ? IDX_W'(i) : idx;
            hit   = hit | match;
        end
        return {hit, idx};
    endfunction

    logic             w_hit_s;
    logic             r_hit_s;
    logic [IDX_W-1:0] w_idx_s;
    logic [IDX_W-1:0] r_idx_s;

    assign {w_hit_s, w_idx_s} = decode(m_waddr);
    assign {r_hit_s, r_idx_s} = decode(m_raddr);
    assign s_waddr = m_waddr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;
    assign s_raddr = m_raddr;

    // Request handshake steering; unmapped requests complete locally so the core never stalls.
    always_comb begin
        s_wready = '0;
        s_rready = '0;
        if (m_wready && w_hit_s) begin
            s_wready[w_idx_s] = 1'b1;
        end else begin
            s_wready = '0;
        end
        if (m_rready && r_hit_s) begin
            s_rready[r_idx_s] = 1'b1;
        end else begin
            s_rready = '0;
        end
        m_wvalid = w_hit_s ? s_wvalid[w_idx_s] : m_wready;
        m_rvalid = r_hit_s ? s_rvalid[r_idx_s] : m_rready;
    end

    logic [RD_LAT-1:0]            acc_q;
    logic [RD_LAT-1:0]            derr_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_q;
    logic                         acc_d;
    logic                         derr_d;
    logic [IDX_W-1:0]             idx_d;

    assign acc_d  = m_rready && m_rvalid;
    assign derr_d = !r_hit_s;
    assign idx_d  = r_idx_s;

    // Read-select pipeline: shifts every cycle so the response slot is fixed at RD_LAT.
    always_ff @(posedge clk) begin
        if (resetb) begin
            acc_q  <= '0;
            derr_q <= '0;
            idx_q  <= '0;
        end else begin
            acc_q[0]  <= acc_d;
            derr_q[0] <= derr_d;
            idx_q[0]  <= idx_d;
            for (int i = 1; i < RD_LAT; i++) begin
                acc_q[i]  <= acc_q[i-1];
                derr_q[i] <= derr_q[i-1];
                idx_q[i]  <= idx_q[i-1];
            end
        end
    end

    logic [31:0] sel_data_s;
    logic        sel_resp_s;

    // Read-data return mux driven by the last pipeline stage.
    always_comb begin
        sel_data_s = 32'h0;
        sel_resp_s = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_data_s = (idx_q[RD_LAT-1] == IDX_W'(i)) ? s_rdata[32*i +: 32] : sel_data_s;
            sel_resp_s = (idx_q[RD_LAT-1] == IDX_W'(i)) ? s_rresp[i] : sel_resp_s;
        end
        if (acc_q[RD_LAT-1] && !derr_q[RD_LAT-1]) begin
            m_rdata = sel_data_s;
            m_rresp = sel_resp_s;
        end else begin
            m_rdata = 32'h0;
            m_rresp = 1'b0;
        end
    end

    logic        err_q, err_d;
    logic        err_wr_q, err_wr_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        w_err_s, r_err_s;
    logic [7:0]  cnt_base_s;
    logic [8:0]  cnt_sum_s;

    // Error record next state; a clear in the same cycle as a new error leaves only the new one.
    always_comb begin
        w_err_s    = m_wready && !w_hit_s;
        r_err_s    = m_rready && !r_hit_s;
        cnt_base_s = err_clr ? 8'h00 : err_cnt_q;
        cnt_sum_s  = {1'b0, cnt_base_s} + {8'h00, w_err_s} + {8'h00, r_err_s};
        err_cnt_d  = cnt_sum_s[8] ? 8'hFF : cnt_sum_s[7:0];
        if ((w_err_s || r_err_s) && (err_clr || !err_q)) begin
            err_d      = 1'b1;
            err_wr_d   = w_err_s;
            err_addr_d = w_err_s ? m_waddr : m_raddr;
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_wr_d   = 1'b0;
            err_addr_d = 32'h0;
        end else begin
            err_d      = err_q;
            err_wr_d   = err_wr_q;
            err_addr_d = err_addr_q;
        end
    end

    // Error record registers.
    always_ff @(posedge clk) begin
        if (resetb) begin
            err_q      <= 1'b0;
            err_wr_q   <= 1'b0;
            err_addr_q <= 32'h0;
            err_cnt_q  <= 8'h00;
        end else begin
            err_q      <= err_d;
            err_wr_q   <= err_wr_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err      = err_q;
    assign err_wr   = err_wr_q;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_dmem_addr_router.sv
// Directed bench for dmem_addr_router: three instances (default map RD_LAT=1, RD_LAT=3,
// all-overlapping map RD_LAT=2) share stimulus; read data is checked through a scoreboard.
module tb_dmem_addr_router;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetb, m_wready, m_rready, err_clr;
    logic [31:0] m_waddr, m_wdata, m_raddr;
    logic [3:0]  m_wstrb;
    logic [1:0]  s_wvalid, s_rvalid, s_rresp;
    logic [63:0] s_rdata;

    logic        wv [3];
    logic        rv [3];
    logic        rresp [3];
    logic        errf [3];
    logic        errwr [3];
    logic [31:0] rdata [3];
    logic [31:0] swaddr [3];
    logic [31:0] swdata [3];
    logic [31:0] sraddr [3];
    logic [31:0] erraddr [3];
    logic [3:0]  swstrb [3];
    logic [1:0]  swready [3];
    logic [1:0]  srready [3];
    logic [7:0]  errcnt [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_addr_router #(
            .NUM_SLAVES(2),
            .SLV_BASE  ({32'h8000_0000, 32'h0000_0000}),
            .SLV_MASK  ((g == 2) ? 64'h0 : {32'hF000_0000, 32'hF000_0000}),
            .RD_LAT    ((g == 0) ? 1 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .clk(clk), .resetb(resetb),
            .m_wready(m_wready), .m_wvalid(wv[g]), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
            .m_rready(m_rready), .m_rvalid(rv[g]), .m_raddr(m_raddr), .m_rresp(rresp[g]), .m_rdata(rdata[g]),
            .s_wready(swready[g]), .s_wvalid(s_wvalid), .s_waddr(swaddr[g]), .s_wdata(swdata[g]), .s_wstrb(swstrb[g]),
            .s_rready(srready[g]), .s_rvalid(s_rvalid), .s_raddr(sraddr[g]), .s_rresp(s_rresp), .s_rdata(s_rdata),
            .err_clr(err_clr), .err(errf[g]), .err_wr(errwr[g]), .err_addr(erraddr[g]), .err_cnt(errcnt[g])
        );
    end

    typedef struct { int due; int inst; logic [31:0] data; logic resp; } exp_t;
    typedef struct { int due; int slv; logic [31:0] data; } rsp_t;
    exp_t sb[$];
    rsp_t rq[$];

    int nchecks = 0;
    int nerrs   = 0;
    int cyc     = 0;
    int k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock: clear requests, present scheduled slave data over idle garbage, check due reads.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        m_wready = 1'b0;
        m_rready = 1'b0;
        err_clr  = 1'b0;
        s_rdata  = {32'hBAD1_BAD1, 32'hBAD0_BAD0};
        s_rresp  = 2'b11;
        for (int i = rq.size() - 1; i >= 0; i--) begin
            if (rq[i].due == cyc) begin
                s_rdata[rq[i].slv*32 +: 32] = rq[i].data;
                s_rresp[rq[i].slv]          = 1'b1;
                rq.delete(i);
            end
        end
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                e = sb[i];
                sb.delete(i);
                chk($sformatf("rdata_i%0d_c%0d", e.inst, cyc), rdata[e.inst], e.data);
                chk($sformatf("rresp_i%0d_c%0d", e.inst, cyc), {31'd0, rresp[e.inst]}, {31'd0, e.resp});
            end
        end
    endtask

    task automatic chk_err(input string tag, input int g, input logic e, input logic w,
                           input logic [31:0] a, input logic [7:0] c);
        chk({tag, "_err"},   {31'd0, errf[g]},  {31'd0, e});
        chk({tag, "_errwr"}, {31'd0, errwr[g]}, {31'd0, w});
        chk({tag, "_addr"},  erraddr[g],        a);
        chk({tag, "_cnt"},   {24'd0, errcnt[g]}, {24'd0, c});
    endtask

    initial begin
        resetb = 1'b1; m_wready = 1'b0; m_rready = 1'b0; err_clr = 1'b0;
        m_waddr = 32'h0; m_wdata = 32'h0; m_raddr = 32'h0; m_wstrb = 4'h0;
        s_wvalid = 2'b00; s_rvalid = 2'b00; s_rresp = 2'b00; s_rdata = 64'h0;
        cycle();
        cycle();
        for (int g = 0; g < 3; g++) begin
            chk_err($sformatf("reset_i%0d", g), g, 1'b0, 1'b0, 32'h0, 8'h00);
            chk($sformatf("reset_rdata_i%0d", g), rdata[g], 32'h0);
            chk($sformatf("reset_rresp_i%0d", g), {31'd0, rresp[g]}, 32'd0);
        end
        resetb = 1'b0;
        cycle();

        // Default map, RD_LAT=1: read to slave1.
        m_rready = 1'b1; m_raddr = 32'h8000_0010; s_rvalid = 2'b10;
        #1;
        chk("rd_srready", {30'd0, srready[0]}, 32'h2);
        chk("rd_mrvalid", {31'd0, rv[0]}, 32'd1);
        chk("rd_sraddr", sraddr[0], 32'h8000_0010);
        rq.push_back('{cyc + 1, 1, 32'h1234_5678});
        sb.push_back('{cyc + 1, 0, 32'h1234_5678, 1'b1});
        cycle();
        // Slave1 not ready: no acceptance, so no data next cycle.
        m_rready = 1'b1; m_raddr = 32'h8000_0020; s_rvalid = 2'b01;
        #1;
        chk("stall_mrvalid", {31'd0, rv[0]}, 32'd0);
        chk("stall_srready", {30'd0, srready[0]}, 32'h2);
        sb.push_back('{cyc + 1, 0, 32'h0, 1'b0});
        cycle();
        // Mapped write to slave0.
        m_wready = 1'b1; m_waddr = 32'h0000_0100; m_wdata = 32'hCAFE_F00D; m_wstrb = 4'b0110; s_wvalid = 2'b01;
        #1;
        chk("wr_swready", {30'd0, swready[0]}, 32'h1);
        chk("wr_mwvalid", {31'd0, wv[0]}, 32'd1);
        chk("wr_swaddr", swaddr[0], 32'h0000_0100);
        chk("wr_swdata", swdata[0], 32'hCAFE_F00D);
        chk("wr_swstrb", {28'd0, swstrb[0]}, 32'h6);
        s_wvalid = 2'b10;
        #1;
        chk("wr_wait_mwvalid", {31'd0, wv[0]}, 32'd0);
        cycle();
        chk_err("mapped_noerr", 0, 1'b0, 1'b0, 32'h0, 8'h00);

        // RD_LAT=3: back-to-back reads to alternating slaves.
        repeat (4) cycle();
        s_rvalid = 2'b11;
        k = cyc;
        m_rready = 1'b1; m_raddr = 32'h0000_0000;
        rq.push_back('{k + 3, 0, 32'h0000_00A0});
        sb.push_back('{k + 2, 1, 32'h0, 1'b0});
        sb.push_back('{k + 3, 1, 32'h0000_00A0, 1'b1});
        cycle();
        m_rready = 1'b1; m_raddr = 32'h8000_0000;
        rq.push_back('{k + 4, 1, 32'h0000_00B0});
        sb.push_back('{k + 4, 1, 32'h0000_00B0, 1'b1});
        sb.push_back('{k + 5, 1, 32'h0, 1'b0});
        repeat (6) cycle();

        // Error record on the default map.
        m_wready = 1'b1; m_waddr = 32'h4000_0004;
        #1;
        chk("uw_mwvalid", {31'd0, wv[0]}, 32'd1);
        chk("uw_swready", {30'd0, swready[0]}, 32'h0);
        cycle();
        chk_err("uw", 0, 1'b1, 1'b1, 32'h4000_0004, 8'd1);
        err_clr = 1'b1;
        cycle();
        chk_err("clr", 0, 1'b0, 1'b0, 32'h0, 8'd0);
        m_wready = 1'b1; m_waddr = 32'h4000_0000; m_rready = 1'b1; m_raddr = 32'h5000_0000;
        #1;
        chk("ur_mrvalid", {31'd0, rv[0]}, 32'd1);
        sb.push_back('{cyc + 1, 0, 32'h0, 1'b0});
        cycle();
        chk_err("wr_rd", 0, 1'b1, 1'b1, 32'h4000_0000, 8'd2);
        repeat (100) begin
            m_wready = 1'b1; m_waddr = 32'h4000_1000;
            cycle();
        end
        chk_err("cnt102", 0, 1'b1, 1'b1, 32'h4000_0000, 8'd102);
        repeat (200) begin
            m_wready = 1'b1; m_waddr = 32'h4000_1000;
            cycle();
        end
        chk_err("cnt_sat", 0, 1'b1, 1'b1, 32'h4000_0000, 8'd255);
        err_clr = 1'b1; m_rready = 1'b1; m_raddr = 32'h6000_0000;
        cycle();
        chk_err("clr_rd", 0, 1'b1, 1'b0, 32'h6000_0000, 8'd1);
        err_clr = 1'b1; m_wready = 1'b1; m_waddr = 32'h4000_0008; m_rready = 1'b1; m_raddr = 32'h7000_0000;
        cycle();
        chk_err("clr_wr_rd", 0, 1'b1, 1'b1, 32'h4000_0008, 8'd2);

        // Overlapping windows: everything goes to slave0, never an error.
        m_wready = 1'b1; m_waddr = 32'h8000_0004; s_wvalid = 2'b01;
        m_rready = 1'b1; m_raddr = 32'hC000_0000; s_rvalid = 2'b01;
        #1;
        chk("ovl_swready", {30'd0, swready[2]}, 32'h1);
        chk("ovl_srready", {30'd0, srready[2]}, 32'h1);
        chk("ovl_mwvalid", {31'd0, wv[2]}, 32'd1);
        chk("ovl_mrvalid", {31'd0, rv[2]}, 32'd1);
        chk("dflt_swready", {30'd0, swready[0]}, 32'h2);
        cycle();
        chk_err("ovl", 2, 1'b0, 1'b0, 32'h0, 8'd0);

        // Reset one cycle after a RD_LAT=2 read is accepted.
        repeat (3) cycle();
        k = cyc;
        m_rready = 1'b1; m_raddr = 32'h1234_0000; s_rvalid = 2'b01;
        #1;
        chk("rst_mrvalid", {31'd0, rv[2]}, 32'd1);
        rq.push_back('{k + 2, 0, 32'hDEAD_BEEF});
        sb.push_back('{k + 1, 2, 32'h0, 1'b0});
        sb.push_back('{k + 2, 2, 32'h0, 1'b0});
        sb.push_back('{k + 3, 2, 32'h0, 1'b0});
        cycle();
        resetb = 1'b1;
        cycle();
        chk_err("rst_mid", 0, 1'b0, 1'b0, 32'h0, 8'd0);
        resetb = 1'b0;
        cycle();
        cycle();
        chk("sb_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
